// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out path: 640x480@60 timing,
// image placement and the packed VRAM word layout.
package vga_pkg;

  localparam int N     = 8;
  localparam int R     = 6;
  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int X0    = 192;
  localparam int Y0    = 112;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_ACT  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int AW  = 14;
  localparam int HCW = 10;
  localparam int VCW = 10;

  typedef logic [N-1:0]        pixel_t;
  typedef logic [R-1:0][N-1:0] vram_word_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick generator and raster counters: tick on every second clk,
// active-low syncs and the image-window flag, all decoded from the counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int V_ACT_LINES  = V_ACT,
  parameter int V_FP_LINES   = V_FP,
  parameter int V_SYNC_LINES = V_SYNC,
  parameter int V_BP_LINES   = V_BP,
  parameter int IMG_TOP      = Y0,
  parameter int IMG_ROWS     = IMG_H
) (
  input  logic           clk,
  input  logic           reset,
  output logic           tick,
  output logic [HCW-1:0] hcnt,
  output logic [VCW-1:0] vcnt,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           in_win,
  output logic           frame_end
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOT - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOT - 1);
  localparam logic [HCW-1:0] HS_BEG = HCW'(H_ACT + H_FP);
  localparam logic [HCW-1:0] HS_END = HCW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VCW-1:0] VS_BEG = VCW'(V_ACT_LINES + V_FP_LINES);
  localparam logic [VCW-1:0] VS_END = VCW'(V_ACT_LINES + V_FP_LINES + V_SYNC_LINES - 1);
  localparam logic [HCW-1:0] X_BEG  = HCW'(X0);
  localparam logic [HCW-1:0] X_END  = HCW'(X0 + IMG_W);
  localparam logic [VCW-1:0] Y_BEG  = VCW'(IMG_TOP);
  localparam logic [VCW-1:0] Y_END  = VCW'(IMG_TOP + IMG_ROWS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      tick <= ~tick;
      if (tick) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  assign hsync_n   = !((hcnt >= HS_BEG) && (hcnt <= HS_END));
  assign vsync_n   = !((vcnt >= VS_BEG) && (vcnt <= VS_END));
  assign in_win    = (hcnt >= X_BEG) && (hcnt < X_END) && (vcnt >= Y_BEG) && (vcnt < Y_END);
  assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

endmodule

// File: rtl/vram_scanout.sv
// VRAM scan-out: streams packed 6-lane words through a one-word prefetch,
// unpacks them into grayscale pixels and registers sync/RGB one tick late.
module vram_scanout
  import vga_pkg::*;
#(
  parameter int V_ACT_LINES  = V_ACT,
  parameter int V_FP_LINES   = V_FP,
  parameter int V_SYNC_LINES = V_SYNC,
  parameter int V_BP_LINES   = V_BP,
  parameter int IMG_TOP      = Y0,
  parameter int IMG_ROWS     = IMG_H
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] rd_addr,
  input  logic [R*N-1:0] rd_data,
  output logic          clk_vga,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [7:0]    o_red,
  output logic [7:0]    o_green,
  output logic [7:0]    o_blue,
  output logic          frame_start
);

  localparam logic [2:0] LANE_LAST = 3'(R - 1);
  localparam logic [2:0] LANE_PREF = 3'(R - 2);

  logic           tick;
  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           hsync_n;
  logic           vsync_n;
  logic           in_win;
  logic           frame_end;

  vram_word_t     rd_word;
  vram_word_t     cur_word;
  vram_word_t     nxt_word;
  logic [AW-1:0]  word_ptr;
  logic [AW-1:0]  word_ptr_nxt;
  logic [2:0]     lane;
  logic [2:0]     lane_nxt;
  logic           cap_nxt;
  logic           at_origin;
  pixel_t         pix;

  vga_timing #(
    .V_ACT_LINES  (V_ACT_LINES),
    .V_FP_LINES   (V_FP_LINES),
    .V_SYNC_LINES (V_SYNC_LINES),
    .V_BP_LINES   (V_BP_LINES),
    .IMG_TOP      (IMG_TOP),
    .IMG_ROWS     (IMG_ROWS)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .in_win    (in_win),
    .frame_end (frame_end)
  );

  assign rd_word   = rd_data;
  assign clk_vga   = tick;
  assign at_origin = (hcnt == '0) && (vcnt == '0);
  assign pix       = in_win ? cur_word[lane] : '0;

  // Rows straddle words, so the pointer only restarts at the frame boundary.
  always_comb begin
    word_ptr_nxt = word_ptr;
    lane_nxt     = lane;
    if (frame_end) begin
      word_ptr_nxt = '0;
      lane_nxt     = '0;
    end else if (in_win) begin
      if (lane == LANE_LAST) begin
        lane_nxt     = '0;
        word_ptr_nxt = word_ptr + 1'b1;
      end else begin
        lane_nxt = lane + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_ptr    <= '0;
      lane        <= '0;
      cur_word    <= '0;
      nxt_word    <= '0;
      rd_addr     <= '0;
      cap_nxt     <= 1'b0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      o_red       <= '0;
      o_green     <= '0;
      o_blue      <= '0;
      frame_start <= 1'b0;
    end else begin
      cap_nxt     <= tick && in_win && (lane == LANE_PREF);
      frame_start <= tick && at_origin;
      if (cap_nxt) begin
        nxt_word <= rd_word;
      end
      if (tick) begin
        word_ptr  <= word_ptr_nxt;
        lane      <= lane_nxt;
        // Address 0 is presented from the last blanking tick; it has settled
        // for two clks by the origin tick, where it becomes the first word.
        rd_addr   <= frame_end ? '0 : word_ptr_nxt + 1'b1;
        if (at_origin) begin
          cur_word <= rd_word;
        end else if (in_win && (lane == LANE_LAST)) begin
          cur_word <= nxt_word;
        end
        hsync_out <= hsync_n;
        vsync_out <= vsync_n;
        o_red     <= pix;
        o_green   <= pix;
        o_blue    <= pix;
      end
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Directed bench for vram_scanout: full horizontal timing, vertical geometry
// shrunk to 12 lines with a 256x4 image at row 2 so whole frames stay short.
module tb_vram_scanout;

  localparam int V_ACT_T  = 8;
  localparam int V_FP_T   = 1;
  localparam int V_SYNC_T = 2;
  localparam int V_BP_T   = 1;
  localparam int Y0_T     = 2;
  localparam int IMG_H_T  = 4;
  localparam int LINE_E   = 1600;
  localparam int FRAME_E  = LINE_E * 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] rd_addr;
  logic [47:0] rd_data;
  logic        clk_vga;
  logic        hsync_out;
  logic        vsync_out;
  logic [7:0]  o_red;
  logic [7:0]  o_green;
  logic [7:0]  o_blue;
  logic        frame_start;

  int n_chk  = 0;
  int n_fail = 0;

  vram_scanout #(
    .V_ACT_LINES  (V_ACT_T),
    .V_FP_LINES   (V_FP_T),
    .V_SYNC_LINES (V_SYNC_T),
    .V_BP_LINES   (V_BP_T),
    .IMG_TOP      (Y0_T),
    .IMG_ROWS     (IMG_H_T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .clk_vga     (clk_vga),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .o_red       (o_red),
    .o_green     (o_green),
    .o_blue      (o_blue),
    .frame_start (frame_start)
  );

  always #10 clk = ~clk;

  logic [47:0] mem [0:16383];
  always @(posedge clk) rd_data <= mem[rd_addr];

  // clk edges since reset release; pixel (h,v) of frame f shows after edge
  // f*FRAME_E + 2*(v*800 + h + 1)
  int ecount;
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  int   hs_fall0 = -1, hs_rise0 = -1, hs_fall1 = -1;
  int   vs_fall0 = -1, vs_rise0 = -1;
  int   fs_e0 = -1, fs_e1 = -1, fs_cnt = 0;
  int   max_addr = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  always @(negedge clk) begin
    if (!reset) begin
      if (hs_prev && !hsync_out) begin
        if (hs_fall0 < 0) hs_fall0 = ecount;
        else if (hs_fall1 < 0) hs_fall1 = ecount;
      end
      if (!hs_prev && hsync_out && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = ecount;
      if (vs_prev && !vsync_out && vs_fall0 < 0) vs_fall0 = ecount;
      if (!vs_prev && vsync_out && vs_fall0 >= 0 && vs_rise0 < 0) vs_rise0 = ecount;
      if (frame_start) begin
        fs_cnt++;
        if (fs_e0 < 0) fs_e0 = ecount;
        else if (fs_e1 < 0) fs_e1 = ecount;
      end
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
    hs_prev = hsync_out;
    vs_prev = vsync_out;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_e(input int target);
    while (ecount < target) @(negedge clk);
  endtask

  task automatic wait_px(input int f, input int h, input int v);
    wait_e(f * FRAME_E + 2 * (v * 800 + h + 1));
  endtask

  function automatic logic [7:0] px_model(input int h, input int v);
    int p;
    logic [47:0] w;
    if (h < 192 || h >= 448 || v < Y0_T || v >= Y0_T + IMG_H_T) return 8'h00;
    p = (v - Y0_T) * 256 + (h - 192);
    w = mem[p / 6];
    return w[(p % 6) * 8 +: 8];
  endfunction

  task automatic chk_reset_state(input string when_tag);
    chk({when_tag, " hsync"},       64'(hsync_out),   64'(1));
    chk({when_tag, " vsync"},       64'(vsync_out),   64'(1));
    chk({when_tag, " red"},         64'(o_red),       64'(0));
    chk({when_tag, " green"},       64'(o_green),     64'(0));
    chk({when_tag, " blue"},        64'(o_blue),      64'(0));
    chk({when_tag, " rd_addr"},     64'(rd_addr),     64'(0));
    chk({when_tag, " frame_start"}, 64'(frame_start), 64'(0));
    chk({when_tag, " clk_vga"},     64'(clk_vga),     64'(0));
  endtask

  initial begin
    for (int w = 0; w < 16384; w++) begin
      for (int k = 0; k < 6; k++) mem[w][k*8 +: 8] = 8'(w * 13 + k * 5 + 17);
    end
    mem[0]           = 48'h060504030201;
    mem[42]          = 48'hA5A4A3A2A1A0;
    mem[170][31:24]  = 8'h7E;
    mem[171]         = 48'hFFFFFFFFFFFF;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_state("in reset");
    reset = 1'b0;

    wait_e(1);
    chk("clk_vga e1", 64'(clk_vga), 64'(1));
    chk("frame_start e1", 64'(frame_start), 64'(0));
    wait_e(2);
    chk("clk_vga e2", 64'(clk_vga), 64'(0));
    chk("frame_start e2", 64'(frame_start), 64'(1));
    wait_e(3);
    chk("clk_vga e3", 64'(clk_vga), 64'(1));
    chk("frame_start e3", 64'(frame_start), 64'(0));
    wait_e(4);
    chk("clk_vga e4", 64'(clk_vga), 64'(0));

    wait_e(3000);
    chk("hsync fall edge", 64'(hs_fall0), 64'(1314));
    chk("hsync low clks", 64'(hs_rise0 - hs_fall0), 64'(192));
    chk("line period", 64'(hs_fall1 - hs_fall0), 64'(1600));

    wait_e(FRAME_E + 10);
    chk("vsync fall edge", 64'(vs_fall0), 64'(14402));
    chk("vsync low clks", 64'(vs_rise0 - vs_fall0), 64'(3200));
    chk("first frame_start", 64'(fs_e0), 64'(2));
    chk("frame period", 64'(fs_e1 - fs_e0), 64'(19200));
    chk("frame_start count", 64'(fs_cnt), 64'(2));

    wait_px(1, 191, 2);
    chk("left of image", 64'(o_red), 64'(0));
    for (int k = 0; k < 6; k++) begin
      wait_px(1, 192 + k, 2);
      chk("word0 red",   64'(o_red),   64'(k + 1));
      chk("word0 green", 64'(o_green), 64'(k + 1));
      chk("word0 blue",  64'(o_blue),  64'(k + 1));
    end
    wait_px(1, 198, 2);
    chk("word1 lane0", 64'(o_red), 64'(px_model(198, 2)));
    wait_px(1, 192, 3);
    chk("row1 start red", 64'(o_red), 64'(8'hA4));
    chk("row1 start blue", 64'(o_blue), 64'(8'hA4));
    wait_px(1, 193, 3);
    chk("row1 second", 64'(o_green), 64'(8'hA5));
    wait_px(1, 300, 4);
    chk("mid image", 64'(o_red), 64'(px_model(300, 4)));
    wait_px(1, 447, 5);
    chk("last pixel", 64'(o_red), 64'(8'h7E));
    chk("last pixel hsync", 64'(hsync_out), 64'(1));
    wait_px(1, 448, 5);
    chk("right of last", 64'(o_red), 64'(0));
    chk("max rd_addr", 64'(max_addr), 64'(171));

    wait_px(1, 300, 7);
    reset = 1'b1;
    #1;
    chk_reset_state("mid-frame reset");
    @(negedge clk);
    reset = 1'b0;

    wait_e(2);
    chk("frame_start after reset", 64'(frame_start), 64'(1));
    wait_px(0, 192, 2);
    chk("restart word0 lane0", 64'(o_red), 64'(8'h01));
    wait_px(0, 193, 2);
    chk("restart word0 lane1", 64'(o_red), 64'(8'h02));
    wait_px(0, 192, 3);
    chk("restart row1", 64'(o_red), 64'(8'hA4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
